// File: rtl/jkff_pkg.sv
// jkff_pkg: shared definitions for the jkff_bank register word.
// Contents:
//   jk_mode_t  - 2-bit mode select type
//   MODE_JK    - per-bit JK behaviour
//   MODE_D     - per-bit D behaviour
//   MODE_T     - per-bit toggle behaviour
//   MODE_COUNT - whole-word up/down counter
package jkff_pkg;

  typedef logic [1:0] jk_mode_t;

  localparam jk_mode_t MODE_JK    = 2'b00;
  localparam jk_mode_t MODE_D     = 2'b01;
  localparam jk_mode_t MODE_T     = 2'b10;
  localparam jk_mode_t MODE_COUNT = 2'b11;

endpackage

// File: rtl/jkff_cell.sv
// jkff_cell: combinational next-state logic for one bit of the bank.
// Ports:
//   ce     - clock enable; when low the bit holds
//   mode   - JK / D / T select (COUNT is resolved in the top, cell holds)
//   j      - J, D or T input depending on mode
//   k      - K input (JK mode only)
//   q      - current registered bit
//   d_next - next-state value of the bit
module jkff_cell
  import jkff_pkg::*;
(
  input  logic     ce,
  input  jk_mode_t mode,
  input  logic     j,
  input  logic     k,
  input  logic     q,
  output logic     d_next
);

  // Default is hold; COUNT mode also holds here since the word-level
  // counter in the top replaces this result.
  always_comb begin
    d_next = q;
    if (ce) begin
      case (mode)
        MODE_JK: begin
          case ({j, k})
            2'b01:   d_next = 1'b0;
            2'b10:   d_next = 1'b1;
            2'b11:   d_next = ~q;
            default: d_next = q;
          endcase
        end
        MODE_D:  d_next = j;
        MODE_T:  d_next = q ^ j;
        default: d_next = q;
      endcase
    end
  end

endmodule

// File: rtl/jkff_bank.sv
// jkff_bank: WIDTH-bit register bank with per-bit JK/D/T behaviour or a
// whole-word up/down counter, plus registered change mask and wrap pulse.
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous active-high reset (loads RESET_VAL)
//   ce      - clock enable; when low, q holds and changed/tc clear
//   mode    - 00=JK, 01=D, 10=T, 11=COUNT
//   j       - per-bit J/D/T; j[0] is the up request in COUNT
//   k       - per-bit K; k[0] is the down request in COUNT
//   q       - registered bank state
//   qn      - bitwise inverse of q
//   changed - registered mask of bits that changed on the last edge
//   tc      - registered pulse: counter wrapped on the last edge
module jkff_bank
  import jkff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  jk_mode_t         mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] changed,
  output logic             tc
);

  logic [WIDTH-1:0] cell_next;
  logic [WIDTH-1:0] q_next;
  logic             tc_next;
  logic             up_req;
  logic             down_req;

  // One combinational cell per bit handles JK, D and T (and ce=0 hold).
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jkff_cell u_cell (
      .ce     (ce),
      .mode   (mode),
      .j      (j[i]),
      .k      (k[i]),
      .q      (q[i]),
      .d_next (cell_next[i])
    );
  end

  // Simultaneous up and down requests cancel to a hold.
  assign up_req   = j[0] & ~k[0];
  assign down_req = ~j[0] & k[0];

  // COUNT overrides the per-bit cells; tc flags a wrap in either direction.
  always_comb begin
    q_next  = cell_next;
    tc_next = 1'b0;
    if (ce && (mode == MODE_COUNT)) begin
      q_next = q;
      if (up_req) begin
        q_next  = q + WIDTH'(1'b1);
        tc_next = &q;
      end else if (down_req) begin
        q_next  = q - WIDTH'(1'b1);
        tc_next = ~|q;
      end
    end
  end

  // With ce low q_next equals q, so changed naturally clears to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= RESET_VAL;
      changed <= '0;
      tc      <= 1'b0;
    end else begin
      q       <= q_next;
      changed <= q_next ^ q;
      tc      <= tc_next;
    end
  end

  assign qn = ~q;

endmodule
